// File: rtl/pcpi_issue.sv
// Issue stage: decodes M-extension instructions, drives the PCPI request with a no-response
// timeout and returns result/illegal/timeout over valid/ack. Optional PCPI_ISSUE_LAT_CNT_EN adds lat_cycles.
module pcpi_issue #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        issue_valid,
  input  logic [31:0] issue_insn,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  output logic        issue_ready,
  output logic        result_valid,
  input  logic        result_ack,
  output logic [31:0] result_data,
  output logic        result_wr,
  output logic        result_illegal,
  output logic        result_timeout,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
`ifdef PCPI_ISSUE_LAT_CNT_EN
  ,
  output logic [CNT_W-1:0] lat_cycles
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 2 || CNT_W == 0) begin : g_bad_param
    $error("pcpi_issue: TIMEOUT must be >= 2 and CNT_W > 0");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e         state_q, state_d;
  logic           issue_ready_q, issue_ready_d;
  logic           result_valid_q, result_valid_d;
  logic [31:0]    result_data_q, result_data_d;
  logic           result_wr_q, result_wr_d;
  logic           illegal_q, illegal_d;
  logic           timeout_q, timeout_d;
  logic           pcpi_valid_q, pcpi_valid_d;
  logic [31:0]    insn_q, insn_d;
  logic [31:0]    rs1_q, rs1_d;
  logic [31:0]    rs2_q, rs2_d;
  logic [TW-1:0]  tmo_q, tmo_d;
`ifdef PCPI_ISSUE_LAT_CNT_EN
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0] lat_q, lat_d;
`endif

  logic legal_c;
  assign legal_c = (issue_insn[6:0] == 7'b0110011) && (issue_insn[31:25] == 7'b0000001)
                   && !issue_insn[14];

  // Next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    issue_ready_d  = issue_ready_q;
    result_valid_d = result_valid_q;
    result_data_d  = result_data_q;
    result_wr_d    = result_wr_q;
    illegal_d      = illegal_q;
    timeout_d      = timeout_q;
    pcpi_valid_d   = pcpi_valid_q;
    insn_d         = insn_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    tmo_d          = tmo_q;
`ifdef PCPI_ISSUE_LAT_CNT_EN
    lat_cnt_d      = (lat_cnt_q == '1) ? lat_cnt_q : lat_cnt_q + CNT_W'(1);
    lat_d          = lat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (issue_valid) begin
          insn_d        = issue_insn;
          rs1_d         = issue_rs1;
          rs2_d         = issue_rs2;
          issue_ready_d = 1'b0;
          if (legal_c) begin
            state_d      = S_BUSY;
            pcpi_valid_d = 1'b1;
            tmo_d        = TW'(TIMEOUT);
`ifdef PCPI_ISSUE_LAT_CNT_EN
            lat_cnt_d    = CNT_W'(1);
`endif
          end else begin
            state_d        = S_RESP;
            result_valid_d = 1'b1;
            result_data_d  = 32'd0;
            result_wr_d    = 1'b0;
            illegal_d      = 1'b1;
            timeout_d      = 1'b0;
          end
        end
      end
      S_BUSY: begin
        if (pcpi_ready) begin
          state_d        = S_RESP;
          pcpi_valid_d   = 1'b0;
          result_valid_d = 1'b1;
          result_data_d  = pcpi_rd;
          result_wr_d    = pcpi_wr;
          illegal_d      = 1'b0;
          timeout_d      = 1'b0;
`ifdef PCPI_ISSUE_LAT_CNT_EN
          lat_d          = lat_cnt_q;
`endif
        end else if (pcpi_wait) begin
          tmo_d = TW'(TIMEOUT);
        end else if (tmo_q == TW'(1)) begin
          state_d        = S_RESP;
          pcpi_valid_d   = 1'b0;
          result_valid_d = 1'b1;
          result_data_d  = 32'd0;
          result_wr_d    = 1'b0;
          illegal_d      = 1'b0;
          timeout_d      = 1'b1;
`ifdef PCPI_ISSUE_LAT_CNT_EN
          lat_d          = lat_cnt_q;
`endif
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_RESP: begin
        if (result_ack) begin
          state_d        = S_IDLE;
          issue_ready_d  = 1'b1;
          result_valid_d = 1'b0;
          illegal_d      = 1'b0;
          timeout_d      = 1'b0;
        end
      end
      default: begin
        state_d        = S_IDLE;
        issue_ready_d  = 1'b1;
        result_valid_d = 1'b0;
        pcpi_valid_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      issue_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      result_data_q  <= 32'd0;
      result_wr_q    <= 1'b0;
      illegal_q      <= 1'b0;
      timeout_q      <= 1'b0;
      pcpi_valid_q   <= 1'b0;
      insn_q         <= 32'd0;
      rs1_q          <= 32'd0;
      rs2_q          <= 32'd0;
      tmo_q          <= '0;
`ifdef PCPI_ISSUE_LAT_CNT_EN
      lat_cnt_q      <= '0;
      lat_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      issue_ready_q  <= issue_ready_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      result_wr_q    <= result_wr_d;
      illegal_q      <= illegal_d;
      timeout_q      <= timeout_d;
      pcpi_valid_q   <= pcpi_valid_d;
      insn_q         <= insn_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      tmo_q          <= tmo_d;
`ifdef PCPI_ISSUE_LAT_CNT_EN
      lat_cnt_q      <= lat_cnt_d;
      lat_q          <= lat_d;
`endif
    end
  end

  assign issue_ready    = issue_ready_q;
  assign result_valid   = result_valid_q;
  assign result_data    = result_data_q;
  assign result_wr      = result_wr_q;
  assign result_illegal = illegal_q;
  assign result_timeout = timeout_q;
  assign pcpi_valid     = pcpi_valid_q;
  assign pcpi_insn      = insn_q;
  assign pcpi_rs1       = rs1_q;
  assign pcpi_rs2       = rs2_q;
`ifdef PCPI_ISSUE_LAT_CNT_EN
  assign lat_cycles     = lat_q;
`endif

endmodule

// File: tb/tb_pcpi_issue.sv
// Randomized bench for pcpi_issue: a transaction-level model predicts per-cycle handshake
// outputs and results; a negedge compare process checks the DUT every cycle.
module tb_pcpi_issue;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        issue_valid;
  logic [31:0] issue_insn, issue_rs1, issue_rs2;
  logic        issue_ready, result_valid, result_ack;
  logic [31:0] result_data;
  logic        result_wr, result_illegal, result_timeout;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait, pcpi_ready;
`ifdef PCPI_ISSUE_LAT_CNT_EN
  logic [31:0] lat_cycles;
  logic [31:0] e_lat;
`endif

  always #5 clk = ~clk;

  pcpi_issue #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .issue_valid(issue_valid), .issue_insn(issue_insn), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_ready(issue_ready),
    .result_valid(result_valid), .result_ack(result_ack), .result_data(result_data),
    .result_wr(result_wr), .result_illegal(result_illegal), .result_timeout(result_timeout),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
`ifdef PCPI_ISSUE_LAT_CNT_EN
    , .lat_cycles(lat_cycles)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // Expected outputs for the current cycle, set by the driver from the model
  logic        chk_en = 1'b0;
  logic        e_ready, e_rv, e_pv;
  logic [31:0] e_insn, e_rs1, e_rs2, e_data;
  logic        e_wr, e_ill, e_to;

  // Observations gathered for hand-computed literal checks
  int          pv_cnt;
  logic [31:0] o_data;
  logic        o_wr, o_ill, o_to;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("issue_ready", 32'(issue_ready), 32'(e_ready));
      chk("result_valid", 32'(result_valid), 32'(e_rv));
      chk("pcpi_valid", 32'(pcpi_valid), 32'(e_pv));
      if (e_pv) begin
        chk("pcpi_insn", pcpi_insn, e_insn);
        chk("pcpi_rs1", pcpi_rs1, e_rs1);
        chk("pcpi_rs2", pcpi_rs2, e_rs2);
      end
      if (e_rv) begin
        chk("result_data", result_data, e_data);
        chk("result_wr", 32'(result_wr), 32'(e_wr));
        chk("result_illegal", 32'(result_illegal), 32'(e_ill));
        chk("result_timeout", 32'(result_timeout), 32'(e_to));
      end
`ifdef PCPI_ISSUE_LAT_CNT_EN
      chk("lat_cycles", lat_cycles, e_lat);
`endif
      if (pcpi_valid) pv_cnt++;
      if (result_valid) begin
        o_data = result_data;
        o_wr   = result_wr;
        o_ill  = result_illegal;
        o_to   = result_timeout;
      end
    end
  end

  // Reference M-extension multiply (funct3 000..011)
  function automatic logic [31:0] mul_ref(input logic [1:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (f3 == 2'd1 || f3 == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    y = (f3 == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return (f3 == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] m_insn(input logic [2:0] f3);
    logic [31:0] w;
    w = {7'b0000001, 5'(2), 5'(1), f3, 5'(3), 7'b0110011};
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    e_ready = 1'b1;
    e_rv    = 1'b0;
    e_pv    = 1'b0;
  endtask

  // mode 0: nw waits then ready; 1: silent stub; 2: random waits, ready at nw+1; 3: ready at nw+1, no waits
  task automatic do_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                       input int mode, input int nw, input int ackd, input logic wrv,
                       input bit lit, input logic [31:0] ld, input logic lill,
                       input logic lto, input int lpv);
    logic pw [1:64];
    logic pr [1:64];
    int   k_end;
    int   last;
    bit   legal, to;
    logic [31:0] prod;
    legal = (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && !insn[14];
    for (int k = 1; k <= 64; k++) begin
      pw[k] = 1'b0;
      pr[k] = 1'b0;
      case (mode)
        0: begin pw[k] = (k <= nw); pr[k] = (k == nw + 1); end
        2: begin pw[k] = (k <= 40) && ($urandom % 3 == 0); pr[k] = (k == nw + 1); end
        3: pr[k] = (k == nw + 1);
        default: ;
      endcase
    end
    k_end = 64;
    to    = 1'b0;
    last  = 0;
    for (int k = 1; k <= 64; k++) begin
      if (pr[k]) begin k_end = k; break; end
      if (pw[k]) last = k;
      else if (k - last == int'(TO)) begin k_end = k; to = 1'b1; break; end
    end
    prod   = mul_ref(insn[13:12], a, b);
    pv_cnt = 0;
    repeat ($urandom % 3) begin
      step(); idle_exp();
      issue_valid = 1'b0;
      pcpi_ready  = 1'($urandom);
      pcpi_wait   = 1'($urandom);
      result_ack  = 1'($urandom);
    end
    step(); idle_exp();
    issue_valid = 1'b1;
    issue_insn  = insn;
    issue_rs1   = a;
    issue_rs2   = b;
    pcpi_ready  = 1'($urandom);
    pcpi_wait   = 1'($urandom);
    result_ack  = 1'($urandom);
    if (legal) begin
      for (int k = 1; k <= k_end; k++) begin
        step();
        e_ready = 1'b0; e_rv = 1'b0; e_pv = 1'b1;
        e_insn = insn; e_rs1 = a; e_rs2 = b;
        issue_valid = 1'($urandom);
        issue_insn  = $urandom;
        pcpi_wait   = pw[k];
        pcpi_ready  = pr[k];
        pcpi_rd     = pr[k] ? prod : $urandom;
        pcpi_wr     = pr[k] ? wrv : 1'($urandom);
        result_ack  = 1'($urandom);
      end
    end
    for (int j = 0; j <= ackd; j++) begin
      step();
      e_ready = 1'b0; e_rv = 1'b1; e_pv = 1'b0;
      e_data = (legal && !to) ? prod : 32'd0;
      e_wr   = legal && !to && wrv;
      e_ill  = !legal;
      e_to   = legal && to;
`ifdef PCPI_ISSUE_LAT_CNT_EN
      if (legal) e_lat = 32'(k_end);
`endif
      result_ack  = (j == ackd);
      issue_valid = 1'($urandom);
      issue_insn  = $urandom;
      pcpi_ready  = 1'($urandom);
      pcpi_wait   = 1'($urandom);
    end
    @(negedge clk);
    #1;
    if (lit) begin
      chk("lit_data", o_data, ld);
      chk("lit_illegal", 32'(o_ill), 32'(lill));
      chk("lit_timeout", 32'(o_to), 32'(lto));
      if (!lill && !lto) chk("lit_wr", 32'(o_wr), 32'(1'b1));
      if (lpv >= 0) chk("lit_busy_cycles", 32'(pv_cnt), 32'(lpv));
    end
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  f7;
    int          r;
    resetn = 1'b0; issue_valid = 1'b0; issue_insn = '0; issue_rs1 = '0; issue_rs2 = '0;
    result_ack = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
`ifdef PCPI_ISSUE_LAT_CNT_EN
    e_lat = 32'd0;
`endif
    #12;
    chk("rst_pcpi_valid", 32'(pcpi_valid), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_result_data", result_data, 32'd0);
    chk("rst_flags", {29'd0, result_wr, result_illegal, result_timeout}, 32'd0);
    chk("rst_pcpi_insn", pcpi_insn, 32'd0);
    chk("rst_pcpi_rs", pcpi_rs1 | pcpi_rs2, 32'd0);
    #10;
    resetn = 1'b1;
    idle_exp();
    chk_en = 1'b1;

    // Directed: MUL 3*7 after 4 waits, MULHU all-ones, ADDI, silent timeout, ready on expiry, DIV
    do_op(m_insn(3'b000), 32'd3, 32'd7, 0, 4, 0, 1'b1, 1'b1, 32'd21, 1'b0, 1'b0, 5);
    do_op(m_insn(3'b011), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1'b1,
          1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    do_op(32'h0000_0013, 32'd5, 32'd9, 0, 0, 0, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 0);
    do_op(m_insn(3'b000), 32'd4, 32'd4, 1, 0, 1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 16);
    do_op(m_insn(3'b001), 32'hFFFF_FFFE, 32'd3, 3, 15, 0, 1'b1,
          1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 16);
    do_op(m_insn(3'b000), 32'd6, 32'd6, 0, 2, 5, 1'b1, 1'b1, 32'd36, 1'b0, 1'b0, 3);
    do_op(m_insn(3'b100), 32'd8, 32'd2, 0, 0, 0, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 0);

    // Mid-operation reset
    step(); idle_exp();
    issue_valid = 1'b1; issue_insn = m_insn(3'b000); issue_rs1 = 32'd5; issue_rs2 = 32'd6;
    pcpi_wait = 1'b0; pcpi_ready = 1'b0; result_ack = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      e_ready = 1'b0; e_rv = 1'b0; e_pv = 1'b1;
      e_insn = m_insn(3'b000); e_rs1 = 32'd5; e_rs2 = 32'd6;
      issue_valid = 1'b0; pcpi_wait = 1'b1;
    end
    #2;
    chk_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("midrst_pcpi_valid", 32'(pcpi_valid), 32'd0);
    chk("midrst_pcpi_insn", pcpi_insn, 32'd0);
    pcpi_wait = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    resetn = 1'b1;
`ifdef PCPI_ISSUE_LAT_CNT_EN
    e_lat = 32'd0;
`endif
    #1;
    chk("postrst_issue_ready", 32'(issue_ready), 32'd1);
    idle_exp();
    chk_en = 1'b1;
    do_op(m_insn(3'b000), 32'd1000, 32'd1000, 0, 1, 0, 1'b1,
          1'b1, 32'd1000000, 1'b0, 1'b0, 2);

    // Randomized operations
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom % 10);
      if (r < 2) begin
        ins = m_insn(3'($urandom));
        case ($urandom % 4)
          0: ins[14] = 1'b1;
          1: begin f7 = 7'($urandom); if (f7 == 7'b0000001) f7 = 7'b0100000; ins[31:25] = f7; end
          2: begin ins[6:0] = 7'($urandom); if (ins[6:0] == 7'b0110011) ins[6:0] = 7'b0010011; end
          default: ins = 32'h0000_0013;
        endcase
      end else begin
        ins = m_insn({1'b0, 2'($urandom)});
        ins[24:15] = 10'($urandom);
        ins[11:7]  = 5'($urandom);
      end
      do_op(ins, $urandom, $urandom, (r == 2) ? 1 : int'($urandom % 4), int'($urandom % 21),
            int'($urandom % 4), 1'($urandom), 1'b0, 32'd0, 1'b0, 1'b0, -1);
    end

    step(); idle_exp();
    issue_valid = 1'b0; result_ack = 1'b0; pcpi_ready = 1'b0; pcpi_wait = 1'b0;
    step();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
